// File: rtl/reg_bank_onehot_pkg.sv
// rtl/reg_bank_onehot_pkg.sv - shared types and one-hot helpers for reg_bank_onehot
package reg_bank_onehot_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } state_e;

  // Helpers take a 32-bit vector; callers zero-extend narrower selects.
  localparam int SEL_MAX = 32;

  function automatic logic is_onehot(input logic [SEL_MAX-1:0] s);
    return (s != '0) && ((s & (s - 32'd1)) == '0);
  endfunction

  function automatic logic [4:0] onehot_to_idx(input logic [SEL_MAX-1:0] s);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < SEL_MAX; i++) begin
      if (s[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_onehot_onehot_check.sv
// rtl/reg_bank_onehot_onehot_check.sv - classifies a select/strobe pair as legal or illegal write
module onehot_check
  import reg_bank_onehot_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IW   = 2
) (
  input  logic [NREG-1:0] sel,
  input  logic            din_valid,
  output logic            legal,
  output logic            illegal,
  output logic [IW-1:0]   idx
);

  logic oh;

  assign oh      = is_onehot(32'(sel));
  assign legal   = din_valid & oh;
  assign illegal = din_valid & ~oh;
  assign idx     = IW'(onehot_to_idx(32'(sel)));

endmodule

// File: rtl/reg_bank_onehot.sv
// rtl/reg_bank_onehot.sv - one-hot loaded register bank publishing packed frames via valid/ack
module reg_bank_onehot
  import reg_bank_onehot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREG-1:0]       sel,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic [NREG*WIDTH-1:0] frame,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic [NREG-1:0]       loaded,
  output logic                  sel_err,
  output logic                  overrun,
  input  logic                  clr_err
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW:0] NREG_A = (AW + 1)'(NREG);

  logic [WIDTH-1:0]      regs_q [NREG];
  logic [NREG-1:0]       loaded_q, loaded_d;
  logic [NREG*WIDTH-1:0] frame_q, snap;
  logic                  sel_err_q, overrun_q;
  state_e                state_q;

  logic                  wr_legal, wr_illegal, complete;
  logic [IW-1:0]         wr_idx;

  onehot_check #(.NREG(NREG), .IW(IW)) u_check (
    .sel       (sel),
    .din_valid (din_valid),
    .legal     (wr_legal),
    .illegal   (wr_illegal),
    .idx       (wr_idx)
  );

  // Completion is judged on the mask including the write happening this cycle.
  always_comb begin
    complete = wr_legal && ((loaded_q | sel) == {NREG{1'b1}});
    loaded_d = loaded_q;
    if (complete)      loaded_d = '0;
    else if (wr_legal) loaded_d = loaded_q | sel;
  end

  always_comb begin
    snap = '0;
    for (int i = 0; i < NREG; i++) begin
      snap[i*WIDTH +: WIDTH] = (wr_legal && sel[i]) ? din : regs_q[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NREG_A) rd_data = regs_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      loaded_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (wr_legal) regs_q[wr_idx] <= din;
      loaded_q  <= loaded_d;
      sel_err_q <= wr_illegal;
    end
  end

  // Handshake FSM; a completion while PEND without ack drops the snapshot and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      frame_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (clr_err) overrun_q <= 1'b0;
      case (state_q)
        ST_EMPTY: begin
          if (complete) begin
            frame_q <= snap;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (complete && frame_ack) begin
            frame_q <= snap;
          end else if (complete) begin
            overrun_q <= 1'b1;
          end else if (frame_ack) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign frame       = frame_q;
  assign frame_valid = (state_q == ST_PEND);
  assign loaded      = loaded_q;
  assign sel_err     = sel_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_reg_bank_onehot.sv
// tb/tb_reg_bank_onehot.sv - self-checking bench for reg_bank_onehot with reference model
module tb_reg_bank_onehot;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = '0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic [31:0] frame;
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic [3:0]  loaded;
  logic        sel_err;
  logic        overrun;
  logic        clr_err = 1'b0;

  int tests = 0;
  int fails = 0;

  reg_bank_onehot #(.WIDTH(8), .NREG(4), .AW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .din         (din),
    .din_valid   (din_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .loaded      (loaded),
    .sel_err     (sel_err),
    .overrun     (overrun),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-register values and a loaded flag per slot.
  bit [7:0]  m_reg [4];
  bit        m_ld  [4];
  bit [31:0] m_frame;
  bit        m_fv, m_ovr, m_serr;
  bit        m_all, m_done;
  bit [31:0] m_snap;
  int        m_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_reg[i] = 0; m_ld[i] = 0; end
      m_frame = 0; m_fv = 0; m_ovr = 0; m_serr = 0;
    end else begin
      m_done = 0;
      m_serr = din_valid && ($countones(sel) != 1);
      if (din_valid && $countones(sel) == 1) begin
        m_k = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) m_k = i;
        m_reg[m_k] = din;
        m_ld[m_k]  = 1;
        m_all = 1;
        for (int i = 0; i < 4; i++) m_all = m_all && m_ld[i];
        if (m_all) begin
          m_done = 1;
          m_snap = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
          for (int i = 0; i < 4; i++) m_ld[i] = 0;
        end
      end
      if (m_done && m_fv && !frame_ack) m_ovr = 1;
      else if (clr_err) m_ovr = 0;
      if (m_done && (!m_fv || frame_ack)) begin
        m_frame = m_snap;
        m_fv = 1;
      end else if (!m_done && m_fv && frame_ack) begin
        m_fv = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_frame", frame, m_frame);
    check("model_frame_valid", frame_valid, m_fv);
    check("model_loaded", loaded, {m_ld[3], m_ld[2], m_ld[1], m_ld[0]});
    check("model_sel_err", sel_err, m_serr);
    check("model_overrun", overrun, m_ovr);
    check("model_rd_data", rd_data, m_reg[rd_addr]);
  end

  task automatic step(input logic [3:0] s, input logic [7:0] d, input logic v,
                      input logic a, input logic c);
    sel = s; din = d; din_valid = v; frame_ack = a; clr_err = c;
    @(posedge clk);
    #1;
    sel = '0; din = '0; din_valid = 1'b0; frame_ack = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    step(s, d, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_frame", frame, 32'h0);
    check("reset_fv", frame_valid, 1'b0);
    check("reset_loaded", loaded, 4'h0);
    check("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1;

    // First frame
    wr(4'b0001, 8'h11); wr(4'b0010, 8'h22); wr(4'b0100, 8'h33); wr(4'b1000, 8'h44);
    check("f1_frame", frame, 32'h44332211);
    check("f1_fv", frame_valid, 1'b1);
    check("f1_loaded", loaded, 4'h0);
    rd_addr = 2'd2; #1;
    check("f1_rd2", rd_data, 8'h33);

    // Overrun: second frame with no ack
    wr(4'b0001, 8'hAA); wr(4'b0010, 8'hBB); wr(4'b0100, 8'hCC); wr(4'b1000, 8'hDD);
    check("ovr_frame_held", frame, 32'h44332211);
    check("ovr_set", overrun, 1'b1);
    check("ovr_fv", frame_valid, 1'b1);
    step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", overrun, 1'b0);

    // Completion with same-cycle ack
    wr(4'b0001, 8'h0A); wr(4'b0010, 8'h0B); wr(4'b0100, 8'h0C);
    step(4'b1000, 8'h0D, 1'b1, 1'b1, 1'b0);
    check("ack_same_frame", frame, 32'h0D0C0B0A);
    check("ack_same_fv", frame_valid, 1'b1);
    check("ack_same_ovr", overrun, 1'b0);
    step(4'b0000, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ack_drop_fv", frame_valid, 1'b0);

    // Illegal selects
    step(4'b0000, 8'h99, 1'b1, 1'b0, 1'b0);
    check("ill_zero_err", sel_err, 1'b1);
    check("ill_zero_loaded", loaded, 4'h0);
    step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ill_pulse_end", sel_err, 1'b0);
    step(4'b0110, 8'h99, 1'b1, 1'b0, 1'b0);
    check("ill_multi_err", sel_err, 1'b1);
    rd_addr = 2'd1; #1;
    check("ill_multi_reg1", rd_data, 8'h0B);
    step(4'b0011, 8'h99, 1'b0, 1'b0, 1'b0);
    check("novalid_no_err", sel_err, 1'b0);
    check("novalid_loaded", loaded, 4'h0);

    // Rewrite reg1 within a frame
    wr(4'b0010, 8'h55);
    wr(4'b0010, 8'h66);
    check("rewrite_loaded", loaded, 4'b0010);
    check("rewrite_err", sel_err, 1'b0);
    wr(4'b0001, 8'h01); wr(4'b0100, 8'h02);
    check("rewrite_not_done", frame_valid, 1'b0);
    wr(4'b1000, 8'h03);
    check("rewrite_frame", frame, 32'h03026601);
    check("rewrite_fv", frame_valid, 1'b1);
    step(4'b0000, 8'h00, 1'b0, 1'b1, 1'b0);

    // Pending frame plus partial frame, then async reset between edges
    wr(4'b0001, 8'h10); wr(4'b0010, 8'h20); wr(4'b0100, 8'h30); wr(4'b1000, 8'h40);
    check("pre_rst_frame", frame, 32'h40302010);
    wr(4'b0001, 8'h77); wr(4'b0010, 8'h88);
    check("pre_rst_loaded", loaded, 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("rst_frame", frame, 32'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_loaded", loaded, 4'h0);
    check("rst_rd", rd_data, 8'h00);
    @(negedge clk); #1 rst_n = 1'b1;
    wr(4'b0100, 8'hE3); wr(4'b0001, 8'hE1); wr(4'b1000, 8'hE4);
    check("post_rst_pending", frame_valid, 1'b0);
    wr(4'b0010, 8'hE2);
    check("post_rst_frame", frame, 32'hE4E3E2E1);
    check("post_rst_fv", frame_valid, 1'b1);
    check("post_rst_ovr", overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
